// File: rtl/config_dispatcher_if.sv
// Stream bundle between the config source, the dispatcher and the per-operator channel consumers.
// The slave modport is the dispatcher side; the master modport is the source/consumer side.
interface config_dispatcher_if #(
  parameter int NUM_CH    = 4,
  parameter int OP_W      = 5,
  parameter int PAYLOAD_W = 113
);
  logic [OP_W+PAYLOAD_W-1:0]    config_in_tdata;
  logic                         config_in_tvalid;
  logic                         config_in_tready;
  logic [NUM_CH*PAYLOAD_W-1:0]  ch_out_tdata;
  logic [NUM_CH-1:0]            ch_out_tvalid;
  logic [NUM_CH-1:0]            ch_out_tready;

  modport master (
    output config_in_tdata, config_in_tvalid,
    input  config_in_tready,
    input  ch_out_tdata, ch_out_tvalid,
    output ch_out_tready
  );

  modport slave (
    input  config_in_tdata, config_in_tvalid,
    output config_in_tready,
    output ch_out_tdata, ch_out_tvalid,
    input  ch_out_tready
  );
endinterface

// File: rtl/config_dispatcher.sv
// In-order dispatcher: buffers config words in a FIFO and routes each payload to the channel named by its operator.
// Define CFG_DISPATCH_ERR_STATUS_EN to add the err_illegal_op / err_count status ports.
module config_dispatcher #(
  parameter int NUM_CH    = 4,
  parameter int OP_W      = 5,
  parameter int PAYLOAD_W = 113,
  parameter int DEPTH     = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  config_dispatcher_if.slave cfgBus,
  output logic               busy
`ifdef CFG_DISPATCH_ERR_STATUS_EN
  ,
  output logic               err_illegal_op,
  output logic [7:0]         err_count
`endif
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = OP_W + PAYLOAD_W;
  localparam logic [31:0] NUM_CH_U = 32'(NUM_CH);

  typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;

  state_t                state_q, state_d;
  logic [WORD_W-1:0]     fifoMem_q [DEPTH];
  logic [PTR_W-1:0]      wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [NUM_CH-1:0]     chValid_q;
  logic [PAYLOAD_W-1:0]  chData_q [NUM_CH];
  logic [NUM_CH*PAYLOAD_W-1:0] chDataFlat;

  logic                  push, pop, load, headLegal, headBlocked;
  logic [OP_W-1:0]       headOp;
  logic [PAYLOAD_W-1:0]  headPayload;
  logic [31:0]           headOpExt;

  // Full is judged on the registered count alone, so a pop never frees a slot in the same cycle.
  assign cfgBus.config_in_tready = (count_q != CNT_W'(DEPTH));
  assign push = cfgBus.config_in_tvalid && cfgBus.config_in_tready;

  always_comb begin
    headOp      = fifoMem_q[rdPtr_q][OP_W-1:0];
    headPayload = fifoMem_q[rdPtr_q][WORD_W-1:OP_W];
    headOpExt   = 32'(headOp);
    headLegal   = headOpExt < NUM_CH_U;
    headBlocked = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (headOpExt == 32'(k)) begin
        headBlocked = chValid_q[k] && !cfgBus.ch_out_tready[k];
      end
    end
    pop     = (state_q != IDLE) && !headBlocked;
    load    = pop && headLegal;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    state_d = state_q;
    if (count_d == '0) begin
      state_d = IDLE;
    end else if (headBlocked) begin
      state_d = STALL;
    end else begin
      state_d = ISSUE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset; only the pointers decide which entries are live.
  always_ff @(posedge clock) begin
    if (push) fifoMem_q[wrPtr_q] <= cfgBus.config_in_tdata;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      chValid_q <= '0;
      for (int k = 0; k < NUM_CH; k++) chData_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (load && (headOpExt == 32'(k))) begin
          chData_q[k]  <= headPayload;
          chValid_q[k] <= 1'b1;
        end else if (cfgBus.ch_out_tready[k]) begin
          chValid_q[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    chDataFlat = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      chDataFlat[k*PAYLOAD_W +: PAYLOAD_W] = chData_q[k];
    end
  end

  assign cfgBus.ch_out_tdata  = chDataFlat;
  assign cfgBus.ch_out_tvalid = chValid_q;
  assign busy = (count_q != '0) || (|chValid_q);

`ifdef CFG_DISPATCH_ERR_STATUS_EN
  logic       errIllegal_q;
  logic [7:0] errCount_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      errIllegal_q <= 1'b0;
      errCount_q   <= '0;
    end else if (pop && !headLegal) begin
      errIllegal_q <= 1'b1;
      if (errCount_q != 8'hFF) errCount_q <= errCount_q + 8'd1;
    end
  end

  assign err_illegal_op = errIllegal_q;
  assign err_count      = errCount_q;
`else
  // Illegal operators are still popped and dropped; only the status reporting is absent.
`endif

endmodule

// File: tb/tb_config_dispatcher.sv
// Self-checking bench for config_dispatcher: queue-level reference model compared every cycle, plus directed literal checks.
// Error-status checks are included when CFG_DISPATCH_ERR_STATUS_EN is defined.
module tb_config_dispatcher;

  localparam int NUM_CH = 4;
  localparam int OP_W   = 5;
  localparam int PW     = 113;
  localparam int DEPTH  = 4;
  localparam int WW     = OP_W + PW;
  localparam int CW     = NUM_CH * PW;

  typedef struct packed {
    logic [PW-1:0]   pl;
    logic [OP_W-1:0] op;
  } word_t;

  logic clock;
  logic reset_n;
  logic busy;
`ifdef CFG_DISPATCH_ERR_STATUS_EN
  logic       err_illegal_op;
  logic [7:0] err_count;
`endif

  config_dispatcher_if #(.NUM_CH(NUM_CH), .OP_W(OP_W), .PAYLOAD_W(PW)) bus ();

  config_dispatcher #(
    .NUM_CH(NUM_CH), .OP_W(OP_W), .PAYLOAD_W(PW), .DEPTH(DEPTH)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .cfgBus  (bus),
    .busy    (busy)
`ifdef CFG_DISPATCH_ERR_STATUS_EN
    ,
    .err_illegal_op (err_illegal_op),
    .err_count      (err_count)
`endif
  );

  int checkCount = 0;
  int passCount  = 0;
  bit cmpEn      = 0;

  // Reference model: a plain queue of pending words plus the contents of each channel register.
  word_t         mQ [$];
  bit            mValid [NUM_CH];
  logic [PW-1:0] mData  [NUM_CH];
`ifdef CFG_DISPATCH_ERR_STATUS_EN
  int mErrCount;
  bit mErrFlag;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [WW-1:0] mkWord(input int op, input logic [PW-1:0] pl);
    logic [OP_W-1:0] o;
    o = OP_W'(op);
    return {pl, o};
  endfunction

  function automatic logic [PW-1:0] randPayload();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[PW-1:0];
  endfunction

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [WW-1:0] d,
                               input logic [NUM_CH-1:0] r, input int cycles);
    bus.config_in_tvalid = v;
    bus.config_in_tdata  = d;
    bus.ch_out_tready    = r;
    repeat (cycles) begin
      @(posedge clock);
      #1;
    end
  endtask

  always @(posedge clock) begin : model
    word_t         h;
    int            opI;
    int            loadCh;
    logic [PW-1:0] loadPl;
    bit            accept;
    loadCh = -1;
    loadPl = '0;
    if (!reset_n) begin
      mQ.delete();
      for (int k = 0; k < NUM_CH; k++) begin
        mValid[k] = 1'b0;
        mData[k]  = '0;
      end
`ifdef CFG_DISPATCH_ERR_STATUS_EN
      mErrCount = 0;
      mErrFlag  = 1'b0;
`endif
    end else begin
      accept = bus.config_in_tvalid && (mQ.size() < DEPTH);
      if (mQ.size() != 0) begin
        h   = mQ[0];
        opI = int'(h.op);
        if (opI >= NUM_CH) begin
          void'(mQ.pop_front());
`ifdef CFG_DISPATCH_ERR_STATUS_EN
          mErrFlag = 1'b1;
          if (mErrCount < 255) mErrCount++;
`endif
        end else if (!mValid[opI] || bus.ch_out_tready[opI]) begin
          void'(mQ.pop_front());
          loadCh = opI;
          loadPl = h.pl;
        end
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (k == loadCh) begin
          mValid[k] = 1'b1;
          mData[k]  = loadPl;
        end else if (bus.ch_out_tready[k]) begin
          mValid[k] = 1'b0;
        end
      end
      if (accept) mQ.push_back(word_t'(bus.config_in_tdata));
    end
  end

  task automatic checkOutput();
    logic [NUM_CH-1:0] expV;
    logic [CW-1:0]     expD;
    bit                anyV;
    expV = '0;
    expD = '0;
    anyV = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      expV[k] = mValid[k];
      expD[k*PW +: PW] = mData[k];
      anyV = anyV | mValid[k];
    end
    check("cyc_tready", CW'(bus.config_in_tready), CW'(mQ.size() < DEPTH));
    check("cyc_tvalid", CW'(bus.ch_out_tvalid), CW'(expV));
    check("cyc_tdata", bus.ch_out_tdata, expD);
    check("cyc_busy", CW'(busy), CW'((mQ.size() != 0) || anyV));
`ifdef CFG_DISPATCH_ERR_STATUS_EN
    check("cyc_err_flag", CW'(err_illegal_op), CW'(mErrFlag));
    check("cyc_err_count", CW'(err_count), CW'(mErrCount));
`endif
  endtask

  always @(negedge clock) begin
    if (cmpEn) checkOutput();
  end

  initial begin : main
    logic [NUM_CH-1:0] rdy;
    logic [31:0]       r32;
    reset_n = 1'b0;
    bus.config_in_tvalid = 1'b0;
    bus.config_in_tdata  = '0;
    bus.ch_out_tready    = '1;
    applyStimulus(1'b0, '0, 4'hF, 2);
    reset_n = 1'b1;
    cmpEn   = 1'b1;
    $display("[TB] reset released");

    check("rst_tready", CW'(bus.config_in_tready), CW'(1));
    check("rst_tvalid", CW'(bus.ch_out_tvalid), CW'(0));
    check("rst_busy", CW'(busy), CW'(0));

    // Single word to channel 0.
    applyStimulus(1'b1, mkWord(0, 113'h1ABC), 4'hF, 1);
    check("single_early_tvalid", CW'(bus.ch_out_tvalid), CW'(0));
    applyStimulus(1'b0, '0, 4'hF, 1);
    check("single_tvalid", CW'(bus.ch_out_tvalid), CW'(4'b0001));
    check("single_tdata0", CW'(bus.ch_out_tdata[0 +: PW]), CW'(113'h1ABC));
    applyStimulus(1'b0, '0, 4'hF, 1);
    check("single_busy_after", CW'(busy), CW'(0));

    // Channel 2 blocked: five back-to-back words fill output register plus FIFO.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, mkWord(2, PW'(32'h200 + i)), 4'b1011, 1);
    bus.config_in_tvalid = 1'b0;
    check("fill_tready_low", CW'(bus.config_in_tready), CW'(0));
    check("fill_ch2_head", CW'(bus.ch_out_tdata[2*PW +: PW]), CW'(113'h200));
    for (int i = 1; i < 5; i++) begin
      applyStimulus(1'b0, '0, 4'hF, 1);
      check("drain_tvalid", CW'(bus.ch_out_tvalid), CW'(4'b0100));
      check("drain_order", CW'(bus.ch_out_tdata[2*PW +: PW]), CW'(PW'(32'h200 + i)));
    end
    applyStimulus(1'b0, '0, 4'hF, 1);
    check("drain_done_tvalid", CW'(bus.ch_out_tvalid), CW'(0));
    check("drain_done_busy", CW'(busy), CW'(0));

    // Head-of-line: op1 blocked holds back a queued op3.
    applyStimulus(1'b1, mkWord(1, 113'hA1), 4'b1101, 1);
    applyStimulus(1'b1, mkWord(1, 113'hB1), 4'b1101, 1);
    applyStimulus(1'b1, mkWord(3, 113'hC3), 4'b1101, 1);
    applyStimulus(1'b0, '0, 4'b1101, 3);
    check("hol_tvalid_blocked", CW'(bus.ch_out_tvalid), CW'(4'b0010));
    check("hol_ch1_a", CW'(bus.ch_out_tdata[1*PW +: PW]), CW'(113'hA1));
    applyStimulus(1'b0, '0, 4'hF, 1);
    check("hol_ch3_still_idle", CW'(bus.ch_out_tvalid), CW'(4'b0010));
    check("hol_ch1_b", CW'(bus.ch_out_tdata[1*PW +: PW]), CW'(113'hB1));
    applyStimulus(1'b0, '0, 4'hF, 1);
    check("hol_ch3_now", CW'(bus.ch_out_tvalid), CW'(4'b1000));
    check("hol_ch3_c", CW'(bus.ch_out_tdata[3*PW +: PW]), CW'(113'hC3));
    applyStimulus(1'b0, '0, 4'hF, 1);

    // Illegal operator is dropped without touching any channel.
    applyStimulus(1'b1, mkWord(7, 113'h777), 4'hF, 1);
    applyStimulus(1'b0, '0, 4'hF, 1);
    check("illegal_tvalid", CW'(bus.ch_out_tvalid), CW'(0));
    check("illegal_busy", CW'(busy), CW'(0));
`ifdef CFG_DISPATCH_ERR_STATUS_EN
    check("illegal_flag", CW'(err_illegal_op), CW'(1));
    check("illegal_count1", CW'(err_count), CW'(1));
`endif
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, mkWord($urandom_range(4, 31), randPayload()), 4'hF, 1);
    applyStimulus(1'b0, '0, 4'hF, 2);
    check("illegal_burst_tvalid", CW'(bus.ch_out_tvalid), CW'(0));
`ifdef CFG_DISPATCH_ERR_STATUS_EN
    check("illegal_count_sat", CW'(err_count), CW'(255));
`endif

    // Reset with three words queued and channel 0 holding.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, mkWord(0, PW'(32'h300 + i)), 4'b1110, 1);
    bus.config_in_tvalid = 1'b0;
    check("prerst_ch0_valid", CW'(bus.ch_out_tvalid), CW'(4'b0001));
    check("prerst_busy", CW'(busy), CW'(1));
    reset_n = 1'b0;
    applyStimulus(1'b0, '0, 4'b1110, 1);
    reset_n = 1'b1;
    check("midrst_tvalid", CW'(bus.ch_out_tvalid), CW'(0));
    check("midrst_busy", CW'(busy), CW'(0));
    check("midrst_tready", CW'(bus.config_in_tready), CW'(1));
    check("midrst_tdata", bus.ch_out_tdata, CW'(0));

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 2000; i++) begin
      r32 = $urandom;
      rdy = r32[NUM_CH-1:0] | r32[NUM_CH+3:4];
      if (i == 900) reset_n = 1'b0;
      applyStimulus(($urandom % 4) != 0, mkWord($urandom_range(0, 5), randPayload()), rdy, 1);
      reset_n = 1'b1;
    end
    applyStimulus(1'b0, '0, 4'hF, 8);
    check("final_idle", CW'(busy), CW'(0));

    cmpEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
